// File: rtl/kronos_tb_mem_pkg.sv
// Shared types and constants for the kronos taint-tracking memory.
// Signal-write addresses, drain FSM encodings and the bitwise strobe merge helper.
package kronos_tb_mem_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] strb_t;

    localparam int ADDR_STOP_SIG = 0;
    localparam int ADDR_TRAP_SIG = 8;

    typedef logic [1:0] drain_state_e;
    localparam drain_state_e DRAIN_IDLE = 2'd0;
    localparam drain_state_e DRAIN_RUN  = 2'd1;
    localparam drain_state_e DRAIN_DONE = 2'd2;

    function automatic data_t strb_merge(input data_t old_w, input data_t new_w, input strb_t strb);
        return (old_w & ~strb) | (new_w & strb);
    endfunction

endpackage

// File: rtl/kronos_taint_mem_if.sv
// One memory port (request, grant, read data) plus the taint shadow of every signal.
// master = core side, slave = memory side.
interface kronos_taint_mem_if #(
    parameter int AW = 15
) ();
    import kronos_tb_mem_pkg::*;

    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    data_t         wdata;
    strb_t         strb;
    logic          we;
    data_t         rdata;

    logic          req_t0;
    logic          gnt_t0;
    logic [AW-1:0] addr_t0;
    data_t         wdata_t0;
    strb_t         strb_t0;
    logic          we_t0;
    data_t         rdata_t0;

    modport master (
        output req, addr, wdata, strb, we,
        output req_t0, addr_t0, wdata_t0, strb_t0, we_t0,
        input  gnt, rdata, gnt_t0, rdata_t0
    );

    modport slave (
        input  req, addr, wdata, strb, we,
        input  req_t0, addr_t0, wdata_t0, strb_t0, we_t0,
        output gnt, rdata, gnt_t0, rdata_t0
    );

endinterface

// File: rtl/kronos_dp_ram.sv
// Two-port read-first word RAM with bitwise write strobe; port 1 wins same-address write collisions.
// Read data is registered and held until the next read on that port.
module kronos_dp_ram
    import kronos_tb_mem_pkg::*;
#(
    parameter int Depth = 1 << 15,
    parameter int AW    = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           re_i,
    input  logic [1:0]           we_i,
    input  logic [1:0][AW-1:0]   addr_i,
    input  logic [1:0][31:0]     wdata_i,
    input  logic [1:0][31:0]     strb_i,
    output logic [1:0][31:0]     rdata_o
);

    data_t            mem_q [Depth];
    logic [1:0][31:0] rdata_q;
    logic             wr0_ok;

    assign wr0_ok = we_i[0] && !(we_i[1] && (addr_i[1] == addr_i[0]));

    // Array is deliberately not reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr0_ok) begin
            mem_q[addr_i[0]] <= strb_merge(mem_q[addr_i[0]], wdata_i[0], strb_i[0]);
        end
        if (we_i[1]) begin
            mem_q[addr_i[1]] <= strb_merge(mem_q[addr_i[1]], wdata_i[1], strb_i[1]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (re_i[p]) rdata_q[p] <= mem_q[addr_i[p]];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/kronos_taint_mem.sv
// Shared instr/data memory with stop/trap signal decode, drain timer and taint event flags.
// Optional taint shadow array enabled by defining SHADOW_TAINT_EN.
module kronos_taint_mem
    import kronos_tb_mem_pkg::*;
#(
    parameter int MemDepth    = 1 << 15,
    parameter int DrainCycles = 50
) (
    input  logic                clk_i,
    input  logic                rst_i,
    kronos_taint_mem_if.slave   instr_if,
    kronos_taint_mem_if.slave   data_if,
    output logic                stop_seen_o,
    output logic                trap_seen_o,
    output logic                stop_data_taint_o,
    output logic                bus_taint_seen_o,
    output logic                taddr_seen_o,
    output logic                done_o
);

    localparam int AW = $clog2(MemDepth);
    localparam int CW = $clog2(DrainCycles + 1);

    logic [1:0]          re, we;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][31:0]    wdata, strb, rdata;
    logic                d_wr, stop_wr, trap_wr;

    assign d_wr    = data_if.req && data_if.we;
    assign stop_wr = d_wr && (data_if.addr == AW'(ADDR_STOP_SIG));
    assign trap_wr = d_wr && (data_if.addr == AW'(ADDR_TRAP_SIG));

    // Port 1 is the data port so it wins collisions; signal writes never reach the array.
    assign re    = {data_if.req && !data_if.we, instr_if.req && !instr_if.we};
    assign we    = {d_wr && !stop_wr && !trap_wr, instr_if.req && instr_if.we};
    assign addr  = {data_if.addr,  instr_if.addr};
    assign wdata = {data_if.wdata, instr_if.wdata};
    assign strb  = {data_if.strb,  instr_if.strb};

    kronos_dp_ram #(.Depth(MemDepth), .AW(AW)) u_data_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (re),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .strb_i  (strb),
        .rdata_o (rdata)
    );

    assign instr_if.gnt   = instr_if.req;
    assign data_if.gnt    = data_if.req;
    assign instr_if.rdata = rdata[0];
    assign data_if.rdata  = rdata[1];

    logic stop_seen_q, trap_seen_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stop_seen_q <= 1'b0;
            trap_seen_q <= 1'b0;
        end else begin
            stop_seen_q <= stop_seen_q | stop_wr;
            trap_seen_q <= trap_seen_q | trap_wr;
        end
    end

    assign stop_seen_o = stop_seen_q;
    assign trap_seen_o = trap_seen_q;

`ifdef SHADOW_TAINT_EN
    logic [1:0][31:0] t_wdata, t_strb, t_rdata;
    logic [1:0]       rd_force, rd_force_q;
    logic             stop_taint_q, bus_taint_q, taddr_q;

    // An address or write-enable taint taints every bit that gets written.
    assign t_wdata[0] = instr_if.wdata_t0 | {32{|instr_if.addr_t0 | instr_if.we_t0}};
    assign t_wdata[1] = data_if.wdata_t0  | {32{|data_if.addr_t0  | data_if.we_t0}};
    assign t_strb[0]  = instr_if.strb | instr_if.strb_t0;
    assign t_strb[1]  = data_if.strb  | data_if.strb_t0;
    assign rd_force   = {|data_if.addr_t0 | data_if.req_t0, |instr_if.addr_t0 | instr_if.req_t0};

    kronos_dp_ram #(.Depth(MemDepth), .AW(AW)) u_taint_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (re),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (t_wdata),
        .strb_i  (t_strb),
        .rdata_o (t_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_force_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (re[p]) rd_force_q[p] <= rd_force[p];
            end
        end
    end

    assign instr_if.gnt_t0   = instr_if.req_t0;
    assign data_if.gnt_t0    = data_if.req_t0;
    assign instr_if.rdata_t0 = t_rdata[0] | {32{rd_force_q[0]}};
    assign data_if.rdata_t0  = t_rdata[1] | {32{rd_force_q[1]}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stop_taint_q <= 1'b0;
            bus_taint_q  <= 1'b0;
            taddr_q      <= 1'b0;
        end else begin
            if (stop_wr && !stop_seen_q && (|data_if.wdata_t0)) stop_taint_q <= 1'b1;
            if (|data_if.rdata_t0) bus_taint_q <= 1'b1;
            if (data_if.req && (|data_if.addr_t0)) taddr_q <= 1'b1;
        end
    end

    assign stop_data_taint_o = stop_taint_q;
    assign bus_taint_seen_o  = bus_taint_q;
    assign taddr_seen_o      = taddr_q;
`else
    logic unused_t0;

    assign unused_t0 = ^{instr_if.req_t0, instr_if.addr_t0, instr_if.wdata_t0, instr_if.strb_t0,
                         instr_if.we_t0, data_if.req_t0, data_if.addr_t0, data_if.wdata_t0,
                         data_if.strb_t0, data_if.we_t0};

    assign instr_if.gnt_t0   = 1'b0;
    assign data_if.gnt_t0    = 1'b0;
    assign instr_if.rdata_t0 = '0;
    assign data_if.rdata_t0  = '0;
    assign stop_data_taint_o = 1'b0;
    assign bus_taint_seen_o  = 1'b0;
    assign taddr_seen_o      = 1'b0;
`endif

    drain_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Only the first stop/trap arms the timer; later ones are ignored until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DRAIN_IDLE: begin
                if (stop_wr || trap_wr) begin
                    state_d = DRAIN_RUN;
                    cnt_d   = CW'(DrainCycles);
                end
            end
            DRAIN_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DRAIN_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DRAIN_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done_o = (state_q == DRAIN_DONE);

endmodule
